// File: rtl/scpad_pkg.sv
// scpad_pkg: shared widths, row-load command type and read-sequencer state encoding
package scpad_pkg;
    localparam int MAX_REQ_WIDTH          = 3;
    localparam int DRAM_VECTOR_MASK_LANES = 64;
    localparam int SPAD_ADDR_W            = 10;
    localparam int XBAR_W                 = 8;
    localparam int DRAM_ADDR_W            = 32;
    localparam int BEAT_BYTES_SHIFT       = 3;

    typedef struct packed {
        logic [DRAM_ADDR_W-1:0]   dram_addr;
        logic [SPAD_ADDR_W-1:0]   spad_addr;
        logic [XBAR_W-1:0]        xbar;
        logic [MAX_REQ_WIDTH-1:0] num_request;
    } dram_rd_cmd_t;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN, ST_WAIT_WR} dram_rd_seq_state_t;
endpackage

// File: rtl/scpad_dram_rd_seq_if.sv
// scpad_dram_rd_seq_if: command, DRAM request/response and latch-side bundle of the read sequencer
interface scpad_dram_rd_seq_if
    import scpad_pkg::*;
#(
    parameter int ADDR_W = DRAM_ADDR_W,
    parameter int REQ_W  = MAX_REQ_WIDTH,
    parameter int BEAT_W = DRAM_VECTOR_MASK_LANES
);
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [ADDR_W-1:0]      cmd_dram_addr;
    logic [SPAD_ADDR_W-1:0] cmd_spad_addr;
    logic [XBAR_W-1:0]      cmd_xbar;
    logic [REQ_W-1:0]       cmd_num_request;
    logic                   dram_req_valid;
    logic                   dram_req_ready;
    logic [ADDR_W-1:0]      dram_req_addr;
    logic [REQ_W-1:0]       dram_req_id;
    logic                   dram_rsp_valid;
    logic [REQ_W-1:0]       dram_rsp_id;
    logic [BEAT_W-1:0]      dram_rsp_data;
    logic                   dram_res_valid;
    logic [REQ_W-1:0]       dram_id;
    logic [BEAT_W-1:0]      dram_rddata;
    logic [REQ_W-1:0]       num_request;
    logic [SPAD_ADDR_W-1:0] spad_addr;
    logic [XBAR_W-1:0]      xbar;
    logic                   row_written;
    logic                   busy;
    logic                   err;

    modport master (
        input  cmd_valid, cmd_dram_addr, cmd_spad_addr, cmd_xbar, cmd_num_request,
               dram_req_ready, dram_rsp_valid, dram_rsp_id, dram_rsp_data, row_written,
        output cmd_ready, dram_req_valid, dram_req_addr, dram_req_id,
               dram_res_valid, dram_id, dram_rddata, num_request, spad_addr, xbar, busy, err
    );

    modport slave (
        output cmd_valid, cmd_dram_addr, cmd_spad_addr, cmd_xbar, cmd_num_request,
               dram_req_ready, dram_rsp_valid, dram_rsp_id, dram_rsp_data, row_written,
        input  cmd_ready, dram_req_valid, dram_req_addr, dram_req_id,
               dram_res_valid, dram_id, dram_rddata, num_request, spad_addr, xbar, busy, err
    );
endinterface

// File: rtl/scpad_dram_rd_seq.sv
// scpad_dram_rd_seq: splits a row load into DRAM read beats, tracks out-of-order returns
// and forwards each beat to the scratchpad write latch while holding the row descriptor
module scpad_dram_rd_seq
    import scpad_pkg::*;
#(
    parameter int ADDR_W     = DRAM_ADDR_W,
    parameter int REQ_W      = MAX_REQ_WIDTH,
    parameter int BEAT_W     = DRAM_VECTOR_MASK_LANES,
    parameter int BEAT_BYTES = 8
) (
    input logic clk,
    input logic rst,
    scpad_dram_rd_seq_if.master io
);
    localparam int SHIFT  = $clog2(BEAT_BYTES);
    localparam int NBEATS = 2 ** REQ_W;
    localparam logic [1:0] IDLE    = ST_IDLE;
    localparam logic [1:0] ISSUE   = ST_ISSUE;
    localparam logic [1:0] DRAIN   = ST_DRAIN;
    localparam logic [1:0] WAIT_WR = ST_WAIT_WR;

    logic [1:0]        state;
    logic [ADDR_W-1:0] base;
    logic [REQ_W-1:0]  issue_cnt;
    logic [REQ_W:0]    rsp_cnt;
    logic [NBEATS-1:0] outstanding, set_mask, clr_mask;
    logic              req_fire, rsp_ok, rsp_bad;

    // a response is only legal for an ID issued earlier in this row and not yet returned
    always_comb begin
        req_fire = state == ISSUE && io.dram_req_ready;
        rsp_ok   = io.dram_rsp_valid && (state == ISSUE || state == DRAIN) && outstanding[io.dram_rsp_id];
        rsp_bad  = io.dram_rsp_valid && !rsp_ok;
        set_mask = req_fire ? NBEATS'(1) << issue_cnt : '0;
        clr_mask = rsp_ok ? NBEATS'(1) << io.dram_rsp_id : '0;
    end

    assign io.cmd_ready      = state == IDLE;
    assign io.busy           = state != IDLE;
    assign io.dram_req_valid = state == ISSUE;
    assign io.dram_req_id    = issue_cnt;
    assign io.dram_req_addr  = base + (ADDR_W'(issue_cnt) << SHIFT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            base              <= '0;
            issue_cnt         <= '0;
            rsp_cnt           <= '0;
            outstanding       <= '0;
            io.dram_res_valid <= 1'b0;
            io.dram_id        <= '0;
            io.dram_rddata    <= '0;
            io.num_request    <= '0;
            io.spad_addr      <= '0;
            io.xbar           <= '0;
            io.err            <= 1'b0;
        end else begin
            io.dram_res_valid <= rsp_ok;
            if (rsp_ok) begin
                io.dram_id     <= io.dram_rsp_id;
                io.dram_rddata <= io.dram_rsp_data;
                rsp_cnt        <= rsp_cnt + (REQ_W+1)'(1);
            end
            if (rsp_bad) io.err <= 1'b1;
            if (req_fire) issue_cnt <= issue_cnt + REQ_W'(1);
            outstanding <= (outstanding | set_mask) & ~clr_mask;
            case (state)
                IDLE: if (io.cmd_valid) begin
                    state          <= ISSUE;
                    base           <= io.cmd_dram_addr;
                    io.num_request <= io.cmd_num_request;
                    io.spad_addr   <= io.cmd_spad_addr;
                    io.xbar        <= io.cmd_xbar;
                    issue_cnt      <= '0;
                    rsp_cnt        <= '0;
                    outstanding    <= '0;
                end
                ISSUE:   if (req_fire && issue_cnt == io.num_request) state <= DRAIN;
                DRAIN:   if (rsp_cnt == (REQ_W+1)'(io.num_request) + (REQ_W+1)'(1)) state <= WAIT_WR;
                WAIT_WR: if (io.row_written) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/scpad_dram_rd_seq.md
# scpad_dram_rd_seq

Upstream feeder for the scratchpad SRAM write latch on the DRAM→scratchpad load path. It accepts one row-load command, splits it into `num_request+1` DRAM read beats and issues them with IDs 0..N. It collects the possibly out-of-order responses and forwards each as a registered `dram_res_valid/dram_id/dram_rddata` beat. It holds `num_request/spad_addr/xbar` stable until the downstream latch reports the assembled row was written.

## Interface
Parameters:
- `ADDR_W`, 32: DRAM byte-address width
- `REQ_W`, `MAX_REQ_WIDTH`: beat-ID / beat-count width (max `2**REQ_W` beats per row)
- `BEAT_W`, `DRAM_VECTOR_MASK_LANES`: data bits per DRAM beat
- `BEAT_BYTES`, 8: DRAM address stride per beat (power of two)
- `SPAD_ADDR_W`, `XBAR_W`: from `scpad_pkg`

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock
- `rst`  in  1  synchronous active-high reset
- `cmd_valid`  in  1  row-load command offered
- `cmd_ready`  out  1  high only in IDLE
- `cmd_dram_addr`  in  ADDR_W  base DRAM address
- `cmd_spad_addr`  in  SPAD_ADDR_W  destination scratchpad row
- `cmd_xbar`  in  XBAR_W  crossbar control for the row
- `cmd_num_request`  in  REQ_W  beats minus one
- `dram_req_valid`  out  1  read request valid
- `dram_req_ready`  in  1  DRAM accepts request
- `dram_req_addr`  out  ADDR_W  beat address
- `dram_req_id`  out  REQ_W  beat index
- `dram_rsp_valid`  in  1  DRAM response (no backpressure)
- `dram_rsp_id`  in  REQ_W  response beat index
- `dram_rsp_data`  in  BEAT_W  response data
- `dram_res_valid`  out  1  forwarded beat valid (to latch)
- `dram_id`  out  REQ_W  forwarded beat index
- `dram_rddata`  out  BEAT_W  forwarded beat data
- `num_request`  out  REQ_W  held row beat count minus one
- `spad_addr`  out  SPAD_ADDR_W  held row address
- `xbar`  out  XBAR_W  held crossbar control
- `row_written`  in  1  one-cycle pulse: latch pushed row to SRAM
- `busy`  out  1  state != IDLE
- `err`  out  1  sticky protocol error

## Operation
- FSM states: IDLE, ISSUE, DRAIN, WAIT_WR.
- IDLE:
  - `cmd_ready=1`.
  - On `cmd_valid`, capture the command into held registers, clear `issue_cnt`, `rsp_cnt` and the `outstanding` mask, then go to ISSUE.
- ISSUE:
  - `dram_req_valid=1`, `dram_req_id=issue_cnt`.
  - `dram_req_addr = base + (issue_cnt << log2(BEAT_BYTES))`, truncated mod 2^ADDR_W (wrap permitted).
  - On handshake, set `outstanding[issue_cnt]` and increment `issue_cnt`.
  - The handshake with `issue_cnt==num_request` moves to DRAIN.
- DRAIN: when `rsp_cnt == num_request+1`, go to WAIT_WR.
- WAIT_WR: on `row_written`, go to IDLE. Held outputs stay unchanged until then.
- Responses are accepted in ISSUE and DRAIN, in any order.
  - A valid response has `outstanding[id]` set. It clears that bit, increments `rsp_cnt`, and is forwarded next cycle.
  - An unexpected response (bit clear, or any state other than ISSUE/DRAIN) is dropped, not forwarded, and sets `err`. `err` clears only on `rst`.
- Simultaneous request handshake and response in the same cycle: both take effect. A set and a clear on different mask bits are independent.
- `row_written` outside WAIT_WR is ignored.

## Timing
- Reset values:
  - state IDLE (so `cmd_ready=1` from the first post-reset cycle); `dram_req_valid=0`, `dram_res_valid=0`, `busy=0`, `err=0`.
  - `dram_id`, `dram_rddata`, `num_request`, `spad_addr`, `xbar`, `dram_req_addr`, `dram_req_id` = 0.
- Command accept to first `dram_req_valid`: 1 cycle. Back-to-back requests issue one per cycle when `dram_req_ready=1`.
- Response in (cycle t) to `dram_res_valid` out: cycle t+1, single-cycle pulse, one beat per cycle max.
- Held outputs change only on the command-accept edge.
- Reset mid-row: everything clears immediately. Late DRAM responses after reset are dropped and set `err`.
- Minimum row turnaround: last response → WAIT_WR, then `row_written` → IDLE on the next edge. A new command can be accepted the cycle after.

## Structure
- `scpad_pkg` holds:
  - the `dram_rd_cmd_t` typedef (dram_addr, spad_addr, xbar, num_request);
  - the `dram_rd_seq_state_t` enum;
  - `BEAT_BYTES_SHIFT`.
- Single module, no sub-modules. The outstanding-ID mask and counters are inline.

## Test plan
- In-order row: `cmd_num_request=3`, base `0x1000`, `dram_req_ready=1`. Required: requests at `0x1000/08/10/18` with IDs 0–3; responses echoed one cycle later; WAIT_WR holds until `row_written`; then IDLE.
- Out-of-order: responses with IDs 2,0,3,1. Required: all four forwarded with matching `dram_id`/data, `err=0`, WAIT_WR reached after the 4th.
- Backpressure: `dram_req_ready` toggles 1,0,0,1… Required: `addr`/`id` stable while stalled, no duplicate IDs.
- Protocol errors: duplicate ID 1 response, or a response in IDLE. Required: dropped, `dram_res_valid=0`, `err` sticky at 1.
- Address wrap: base `0xFFFF_FFF8`, `num_request=1`. Required: addresses `0xFFFF_FFF8`, `0x0000_0000`.
- Mid-row reset: `rst` after 2 of 4 issues. Required: IDLE, all outputs at reset values; a late response sets `err`.
